// File: rtl/sobel_gradient_if.sv
// Pixel-stream / gradient-stream bundle for the Sobel stage.
//   pix_in, pix_valid, sof       : raster pixel stream into the stage
//   vert_out, horz_out, out_valid : signed Gy/Gx gradients out of the stage
// master: the side that produces pixels and consumes gradients.
// slave : the Sobel stage itself.
interface sobel_gradient_if;
  logic        [7:0]  pix_in;
  logic               pix_valid;
  logic               sof;
  logic signed [15:0] vert_out;
  logic signed [15:0] horz_out;
  logic               out_valid;

  modport master (
    output pix_in, pix_valid, sof,
    input  vert_out, horz_out, out_valid
  );

  modport slave (
    input  pix_in, pix_valid, sof,
    output vert_out, horz_out, out_valid
  );
endinterface

// File: rtl/sobel_gradient.sv
// Streaming 3x3 Sobel convolution stage.
// Buffers two raster lines, keeps a 3x3 pixel window, and emits signed
// vertical (Gy) and horizontal (Gx) gradients for every interior pixel,
// one cycle after the pixel completing that window is accepted.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous, active-high; clears counters, window, outputs
//   bus    : slave side of sobel_gradient_if
//            pix_in/pix_valid/sof in, vert_out/horz_out/out_valid out
module sobel_gradient #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic            clk,
  input  logic            reset,
  sobel_gradient_if.slave bus
);

  localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [CW-1:0] cur_col;
  logic [RW-1:0] cur_row;

  // line1 holds row r-1, line2 holds row r-2 (not reset; border rule masks them)
  logic [7:0] line1 [WIDTH];
  logic [7:0] line2 [WIDTH];

  // w[row][col], row 0 = oldest line, col 2 = newest column
  logic [7:0] w [3][3];

  logic               accept;
  logic               qual;
  logic signed [15:0] vert_q;
  logic signed [15:0] horz_q;
  logic               valid_q;
  logic        [15:0] vert_c;
  logic        [15:0] horz_c;

  assign accept = bus.pix_valid;

  // sof relocates the pixel being accepted to (0,0)
  always_comb begin
    cur_col = col;
    cur_row = row;
    if (bus.sof) begin
      cur_col = '0;
      cur_row = '0;
    end
  end

  function automatic logic [15:0] ext(input logic [7:0] p);
    return {8'd0, p};
  endfunction

  // Modular 16-bit arithmetic yields the correct two's-complement result
  always_comb begin
    horz_c = (ext(w[0][2]) + (ext(w[1][2]) << 1) + ext(w[2][2]))
           - (ext(w[0][0]) + (ext(w[1][0]) << 1) + ext(w[2][0]));
    vert_c = (ext(w[2][0]) + (ext(w[2][1]) << 1) + ext(w[2][2]))
           - (ext(w[0][0]) + (ext(w[0][1]) << 1) + ext(w[0][2]));
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      line1[cur_col] <= bus.pix_in;
      line2[cur_col] <= line1[cur_col];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col     <= '0;
      row     <= '0;
      qual    <= 1'b0;
      valid_q <= 1'b0;
      vert_q  <= '0;
      horz_q  <= '0;
      for (int unsigned i = 0; i < 3; i++) begin
        for (int unsigned j = 0; j < 3; j++) begin
          w[i][j] <= '0;
        end
      end
    end else begin
      // Window settled at the accept edge; result registered one edge later
      valid_q <= qual;
      if (qual) begin
        vert_q <= vert_c;
        horz_q <= horz_c;
      end
      qual <= 1'b0;
      if (accept) begin
        for (int unsigned i = 0; i < 3; i++) begin
          w[i][0] <= w[i][1];
          w[i][1] <= w[i][2];
        end
        w[0][2] <= line2[cur_col];
        w[1][2] <= line1[cur_col];
        w[2][2] <= bus.pix_in;
        qual    <= (cur_row >= ROW_TWO) && (cur_col >= COL_TWO);
        if (cur_col == COL_LAST) begin
          col <= '0;
          row <= (cur_row == ROW_LAST) ? '0 : cur_row + ROW_ONE;
        end else begin
          col <= cur_col + COL_ONE;
          row <= cur_row;
        end
      end
    end
  end

  assign bus.vert_out  = vert_q;
  assign bus.horz_out  = horz_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_sobel_gradient.sv
// Self-checking bench for sobel_gradient (WIDTH=4, HEIGHT=4).
// A raster-position model keeps every pixel of the current frame in an
// image array and computes Sobel gradients directly from it.
module tb_sobel_gradient;
  localparam int W = 4;
  localparam int H = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  sobel_gradient_if bus ();

  sobel_gradient #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int v;
    int h;
    int due;
  } exp_t;

  exp_t expq[$];
  exp_t e;
  int   obs_v[$];
  int   obs_h[$];
  int   n_chk   = 0;
  int   n_fail  = 0;
  int   neg_cnt = 0;
  int   last_v  = 0;
  int   last_h  = 0;
  int   img[H][W];
  int   frame[H][W];
  int   mr = 0;
  int   mc = 0;

  task automatic check(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  // Model of one accepted pixel: standard Sobel centred at (r-1,c-1)
  task automatic model_accept(input int p, input bit s);
    int gx, gy;
    if (s) begin
      mr = 0;
      mc = 0;
    end
    img[mr][mc] = p;
    if (mr >= 2 && mc >= 2) begin
      gx = (img[mr-2][mc] + 2*img[mr-1][mc] + img[mr][mc])
         - (img[mr-2][mc-2] + 2*img[mr-1][mc-2] + img[mr][mc-2]);
      gy = (img[mr][mc-2] + 2*img[mr][mc-1] + img[mr][mc])
         - (img[mr-2][mc-2] + 2*img[mr-2][mc-1] + img[mr-2][mc]);
      expq.push_back('{gy, gx, neg_cnt + 2});
    end
    mc++;
    if (mc == W) begin
      mc = 0;
      mr++;
      if (mr == H) mr = 0;
    end
  endtask

  // Compare process: checks outputs each cycle at the falling edge
  always @(negedge clk) begin
    neg_cnt++;
    if (!reset) begin
      if (bus.out_valid) begin
        obs_v.push_back(int'(bus.vert_out));
        obs_h.push_back(int'(bus.horz_out));
        if (expq.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          e = expq.pop_front();
          check("latency", neg_cnt, e.due);
          check("vert", int'(bus.vert_out), e.v);
          check("horz", int'(bus.horz_out), e.h);
        end
        last_v = int'(bus.vert_out);
        last_h = int'(bus.horz_out);
      end else begin
        check("hold_vert", int'(bus.vert_out), last_v);
        check("hold_horz", int'(bus.horz_out), last_h);
        if (expq.size() > 0 && expq[0].due < neg_cnt) begin
          check("missing_valid", 0, 1);
          void'(expq.pop_front());
        end
      end
    end
  end

  task automatic send(input int p, input bit s);
    bus.pix_in    = 8'(p);
    bus.pix_valid = 1'b1;
    bus.sof       = s;
    @(posedge clk);
    model_accept(p, s);
    #1;
    bus.pix_valid = 1'b0;
    bus.sof       = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input bit first_sof, input int maxgap);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        send(frame[r][c], first_sof && r == 0 && c == 0);
        if (maxgap > 0) idle(int'($urandom_range(maxgap, 0)));
      end
    end
  endtask

  task automatic clear_obs();
    obs_v.delete();
    obs_h.delete();
  endtask

  task automatic pin_outputs(input string name, input int v, input int h);
    check({name, "_count"}, obs_v.size(), 4);
    for (int i = 0; i < obs_v.size(); i++) begin
      check({name, "_vert"}, obs_v[i], v);
      check({name, "_horz"}, obs_h[i], h);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    expq.delete();
    mr = 0;
    mc = 0;
    last_v = 0;
    last_h = 0;
    #1;
    check("reset_valid", int'(bus.out_valid), 0);
    check("reset_vert", int'(bus.vert_out), 0);
    check("reset_horz", int'(bus.horz_out), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.pix_in    = 8'd0;
    bus.pix_valid = 1'b0;
    bus.sof       = 1'b0;
    #2;
    apply_reset();
    idle(2);

    // Flat frame
    clear_obs();
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) frame[r][c] = 100;
    send_frame(1'b1, 0);
    idle(4);
    pin_outputs("flat", 0, 0);

    // Vertical edge
    clear_obs();
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) frame[r][c] = (c >= 2) ? 255 : 0;
    send_frame(1'b1, 0);
    idle(4);
    pin_outputs("vedge", 0, 1020);

    // Row ramp and its negation
    clear_obs();
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) frame[r][c] = 10 * r;
    send_frame(1'b1, 0);
    idle(4);
    pin_outputs("ramp", 80, 0);
    clear_obs();
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) frame[r][c] = 30 - 10 * r;
    send_frame(1'b1, 0);
    idle(4);
    pin_outputs("nramp", -80, 0);

    // Vertical edge with random pix_valid gaps
    clear_obs();
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) frame[r][c] = (c >= 2) ? 255 : 0;
    send_frame(1'b1, 3);
    idle(4);
    pin_outputs("gaps", 0, 1020);

    // sof mid-frame at (2,1), then a full random frame
    clear_obs();
    for (int r = 0; r < 2; r++) for (int c = 0; c < W; c++) send(int'($urandom_range(255, 0)), r == 0 && c == 0);
    send(int'($urandom_range(255, 0)), 1'b0);
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) frame[r][c] = int'($urandom_range(255, 0));
    send_frame(1'b1, 0);
    idle(4);
    check("sof_mid_count", obs_v.size(), 4);

    // Reset mid-row 3 with an output pending, then a frame without sof
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) frame[r][c] = (c >= 2) ? 255 : 0;
    for (int r = 0; r < 3; r++) for (int c = 0; c < W; c++) send(frame[r][c], r == 0 && c == 0);
    for (int c = 0; c < 3; c++) send(frame[3][c], 1'b0);
    apply_reset();
    clear_obs();
    idle(2);
    check("post_reset_quiet", obs_v.size(), 0);
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) frame[r][c] = 10 * r;
    send_frame(1'b0, 0);
    idle(4);
    pin_outputs("after_reset", 80, 0);

    // Random frames with random gaps
    clear_obs();
    for (int f = 0; f < 3; f++) begin
      for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) frame[r][c] = int'($urandom_range(255, 0));
      send_frame(1'($urandom_range(1, 0)), 2);
    end
    idle(4);
    check("random_count", obs_v.size(), 12);
    check("queue_empty", expq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
